// File: rtl/uart_rx_block_if.sv
// Block handshake between the UART receiver and the AES core.
// The receiver drives the master side; the AES core is the slave.
interface uart_rx_block_if;
   logic [127:0] block_data;
   logic         block_valid;
   logic         block_ready;

   modport master (
      output block_data,
      output block_valid,
      input  block_ready
   );

   modport slave (
      input  block_data,
      input  block_valid,
      output block_ready
   );
endinterface

// File: rtl/uart_rx_block.sv
// 8N1 UART receiver that packs 16 bytes into one 128-bit AES input block.
// It also reports framing errors, block overruns and partial-block timeouts.
module uart_rx_block #(
   parameter int CLK_FREQ      = 50_000_000,
   parameter int BAUD_RATE     = 115_200,
   parameter int TIMEOUT_BAUDS = 20
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   rx,
   uart_rx_block_if.master        blk,
   output logic [4:0]             byte_count,
   output logic                   frame_err,
   output logic                   overrun,
   output logic                   partial_drop
);

   localparam int BAUD_DIV    = CLK_FREQ / BAUD_RATE;
   localparam int HALF_DIV    = BAUD_DIV / 2;
   localparam int TIMEOUT_CYC = TIMEOUT_BAUDS * BAUD_DIV;

   localparam logic [15:0] BAUD_LAST    = 16'(BAUD_DIV - 1);
   localparam logic [15:0] HALF_LAST    = 16'(HALF_DIV - 1);
   localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t         r_state;
   state_t         w_nextState;
   logic           r_rxMeta;
   logic           r_rxSync;
   logic [15:0]    r_baudCnt;
   logic [2:0]     r_bitIdx;
   logic [7:0]     r_shift;
   logic [119:0]   r_assembly;
   logic [4:0]     r_byteCount;
   logic [23:0]    r_idleCnt;
   logic [127:0]   r_blockData;
   logic           r_blockValid;
   logic           r_frameErr;
   logic           r_overrun;
   logic           r_partialDrop;

   logic           w_tick;
   logic           w_byteAccept;
   logic           w_stopErr;
   logic           w_blockDone;
   logic           w_outFree;
   logic           w_load;
   logic           w_timeout;
   logic [127:0]   w_fullBlock;

   // Only the 15 earlier bytes are stored; the 16th comes straight from the shifter.
   assign w_fullBlock = {r_assembly, r_shift};
   assign w_blockDone = w_byteAccept && (r_byteCount == 5'd15);
   assign w_outFree   = !r_blockValid || blk.block_ready;
   assign w_load      = w_blockDone && w_outFree;
   assign w_timeout   = (r_state == IDLE) && (r_byteCount != 5'd0) && (r_idleCnt == TIMEOUT_LAST);

   assign blk.block_data  = r_blockData;
   assign blk.block_valid = r_blockValid;
   assign byte_count      = r_byteCount;
   assign frame_err       = r_frameErr;
   assign overrun         = r_overrun;
   assign partial_drop    = r_partialDrop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState  = r_state;
      w_tick       = 1'b0;
      w_byteAccept = 1'b0;
      w_stopErr    = 1'b0;
      case (r_state)
         IDLE: begin
            if (!r_rxSync) w_nextState = START;
         end
         START: begin
            if (r_baudCnt == HALF_LAST) begin
               w_tick      = 1'b1;
               w_nextState = r_rxSync ? IDLE : DATA;
            end
         end
         DATA: begin
            if (r_baudCnt == BAUD_LAST) begin
               w_tick = 1'b1;
               if (r_bitIdx == 3'd7) w_nextState = STOP;
            end
         end
         STOP: begin
            if (r_baudCnt == BAUD_LAST) begin
               w_tick = 1'b1;
               if (r_rxSync) begin
                  w_byteAccept = 1'b1;
                  w_nextState  = IDLE;
               end else begin
                  w_stopErr   = 1'b1;
                  w_nextState = BREAK;
               end
            end
         end
         BREAK: begin
            if (r_rxSync) w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Bit timing, deserialisation, block assembly, timeout and output handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rxMeta      <= 1'b1;
         r_rxSync      <= 1'b1;
         r_baudCnt     <= 16'd0;
         r_bitIdx      <= 3'd0;
         r_shift       <= 8'd0;
         r_assembly    <= 120'd0;
         r_byteCount   <= 5'd0;
         r_idleCnt     <= 24'd0;
         r_blockData   <= 128'd0;
         r_blockValid  <= 1'b0;
         r_frameErr    <= 1'b0;
         r_overrun     <= 1'b0;
         r_partialDrop <= 1'b0;
      end else begin
         r_rxMeta <= rx;
         r_rxSync <= r_rxMeta;

         if ((r_state == START || r_state == DATA || r_state == STOP) && !w_tick) begin
            r_baudCnt <= r_baudCnt + 16'd1;
         end else begin
            r_baudCnt <= 16'd0;
         end

         if (r_state == START && w_tick) begin
            r_bitIdx <= 3'd0;
         end else if (r_state == DATA && w_tick) begin
            r_shift  <= {r_rxSync, r_shift[7:1]};
            r_bitIdx <= r_bitIdx + 3'd1;
         end

         if (w_byteAccept) begin
            r_assembly  <= {r_assembly[111:0], r_shift};
            r_byteCount <= w_blockDone ? 5'd0 : r_byteCount + 5'd1;
         end else if (w_timeout) begin
            r_byteCount <= 5'd0;
         end

         if (r_state == IDLE && r_byteCount != 5'd0 && !w_timeout) begin
            r_idleCnt <= r_idleCnt + 24'd1;
         end else begin
            r_idleCnt <= 24'd0;
         end

         if (w_load) begin
            r_blockData  <= w_fullBlock;
            r_blockValid <= 1'b1;
         end else if (blk.block_ready) begin
            r_blockValid <= 1'b0;
         end

         r_frameErr    <= w_stopErr;
         r_overrun     <= w_blockDone && !w_outFree;
         r_partialDrop <= w_timeout;
      end
   end

endmodule
